// File: rtl/shift_sequencer_if.sv
// Request/result bundle for shift_sequencer: start handshake, operand, shift controls and result.
interface shift_sequencer_if;
  logic        start;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shamt;
  logic [1:0]  ctrl_shiftop;
  logic        ready;
  logic        done;
  logic [31:0] data_result;

  modport master (
    output start, data_operandA, ctrl_shamt, ctrl_shiftop,
    input  ready, done, data_result
  );

  modport slave (
    input  start, data_operandA, ctrl_shamt, ctrl_shiftop,
    output ready, done, data_result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter resolving one power-of-two stage (16,8,4,2,1) per cycle.
// Define SHIFT_SEQ_EARLY_DONE_EN to finish as soon as the remaining shift-amount bits are zero.
module shift_sequencer (
  input  logic               clock,
  input  logic               reset_n,
  shift_sequencer_if.slave   bus
);

  localparam int unsigned DataW  = 32;
  localparam int unsigned ShamtW = 5;
  localparam int unsigned StageW = 3;
  localparam logic [StageW-1:0] StageTop = StageW'(4);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DataW-1:0]    result_q, result_d;
  logic [ShamtW-1:0]   shamt_q, shamt_d;
  logic [1:0]          op_q, op_d;
  logic [StageW-1:0]   stage_q, stage_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;

  logic [ShamtW-1:0]   amt_c;
  logic [DataW-1:0]    shifted_c;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      shamt_q  <= '0;
      op_q     <= '0;
      stage_q  <= StageTop;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      shamt_q  <= shamt_d;
      op_q     <= op_d;
      stage_q  <= stage_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  // Current stage's shift distance 2^k and the one-stage shift of the working register.
  always_comb begin
    amt_c     = ShamtW'(ShamtW'(1) << stage_q);
    shifted_c = result_q;
    case (op_q)
      2'b00:   shifted_c = result_q << amt_c;
      2'b10:   shifted_c = DataW'($signed(result_q) >>> amt_c);
      default: shifted_c = result_q >> amt_c;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    shamt_d  = shamt_q;
    op_d     = op_q;
    stage_d  = stage_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          result_d = bus.data_operandA;
          shamt_d  = bus.ctrl_shamt;
          op_d     = bus.ctrl_shiftop;
          stage_d  = StageTop;
`ifdef SHIFT_SEQ_EARLY_DONE_EN
          state_d  = (bus.ctrl_shamt == '0) ? ST_DONE : ST_SHIFT;
`else
          state_d  = ST_SHIFT;
`endif
        end
      end
      ST_SHIFT: begin
        if ((shamt_q & amt_c) != '0) result_d = shifted_c;
        stage_d = stage_q - StageW'(1);
`ifdef SHIFT_SEQ_EARLY_DONE_EN
        // Lower bits all clear: nothing left to apply.
        if ((shamt_q & (amt_c - ShamtW'(1))) == '0) state_d = ST_DONE;
`else
        if (stage_q == '0) state_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        stage_d = StageTop;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  assign bus.ready       = ready_q;
  assign bus.done        = done_q;
  assign bus.data_result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases, mid-op reset, ignored start, random ops.
module tb_shift_sequencer;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference result: the whole shift in one step.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] sh,
                                            input logic [1:0] op);
    logic signed [31:0] s;
    s = a;
    case (op)
      2'b00:   return a << sh;
      2'b10:   return 32'(s >>> sh);
      default: return a >> sh;
    endcase
  endfunction

  // Cycle (relative to acceptance cycle c0) in which done is expected.
  function automatic int exp_lat(input logic [4:0] sh);
`ifdef SHIFT_SEQ_EARLY_DONE_EN
    int tz;
    if (sh == 5'd0) return 1;
    tz = 0;
    while (sh[tz] == 1'b0) tz++;
    return 1 + (5 - tz);
`else
    return 6;
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic watch_no_done(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      step();
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL %s: spurious done at cycle %0d (done=%b, expected 0)", name, i, bus.done);
      end
    end
  endtask

  // Accept one op at the next edge and check done timing, result, and return to idle.
  task automatic run_op(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] op,
                        input string name);
    logic [31:0] exp_res;
    int          lat;
    int          cyc;
    exp_res = ref_shift(a, sh, op);
    lat     = exp_lat(sh);
    @(negedge clock);
    bus.start         = 1'b1;
    bus.data_operandA = a;
    bus.ctrl_shamt    = sh;
    bus.ctrl_shiftop  = op;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_at_c0: got %b expected 1", name, bus.ready);
    end
    step();
    bus.start         = 1'b0;
    bus.data_operandA = ~a;
    bus.ctrl_shamt    = ~sh;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc != lat) begin
      errors++;
      $display("FAIL %s done_cycle: got c%0d expected c%0d", name, cyc, lat);
    end
    checks++;
    if (bus.data_result !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, bus.data_result, exp_res);
    end
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.data_result !== exp_res) begin
      errors++;
      $display("FAIL %s after_done: done=%b ready=%b result=%h expected done=0 ready=1 result=%h",
               name, bus.done, bus.ready, bus.data_result, exp_res);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.data_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: ready=%b done=%b result=%h expected 1 0 00000000",
               bus.ready, bus.done, bus.data_result);
    end
    watch_no_done(8, "idle_no_done");
  endtask

  task automatic test_directed();
    run_op(32'h0000_0001, 5'd31, 2'b00, "sll_31");
    run_op(32'h8000_00F0, 5'd4,  2'b10, "sra_sign");
    run_op(32'h8000_00F0, 5'd4,  2'b01, "srl_4");
    run_op(32'h8000_00F0, 5'd4,  2'b11, "op11_srl");
    run_op(32'h8000_0000, 5'd31, 2'b10, "sra_31");
    run_op(32'hDEAD_BEEF, 5'd0,  2'b10, "shamt_0");
  endtask

  task automatic test_ignored_start();
    int cyc;
    int ndone;
    @(negedge clock);
    bus.start         = 1'b1;
    bus.data_operandA = 32'hFFFF_0000;
    bus.ctrl_shamt    = 5'd8;
    bus.ctrl_shiftop  = 2'b01;
    step();
    bus.start         = 1'b0;
    bus.data_operandA = 32'h1357_9BDF;
    bus.ctrl_shamt    = 5'd3;
    bus.ctrl_shiftop  = 2'b00;
    ndone = 0;
    for (cyc = 1; cyc <= 14; cyc++) begin
      bus.start = (cyc == 2);
      if (bus.done === 1'b1) begin
        ndone++;
        checks++;
        if (cyc != exp_lat(5'd8) || bus.data_result !== 32'h00FF_FF00) begin
          errors++;
          $display("FAIL ignored_start result: c%0d %h expected c%0d 00ffff00",
                   cyc, bus.data_result, exp_lat(5'd8));
        end
      end
      step();
    end
    bus.start = 1'b0;
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL ignored_start done_count: got %0d expected 1", ndone);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    bus.start         = 1'b1;
    bus.data_operandA = 32'hA5A5_A5A5;
    bus.ctrl_shamt    = 5'd31;
    bus.ctrl_shiftop  = 2'b00;
    step();
    bus.start = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checks++;
    if (bus.data_result !== 32'h0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: result=%h ready=%b done=%b expected 00000000 1 0",
               bus.data_result, bus.ready, bus.done);
    end
    watch_no_done(10, "reset_mid_no_done");
  endtask

  task automatic test_early_done();
    run_op(32'h1234_5678, 5'd16, 2'b00, "early_16");
    run_op(32'h1234_5678, 5'd0,  2'b00, "early_0");
    run_op(32'h1234_5678, 5'd1,  2'b10, "early_1");
    run_op(32'hF000_0000, 5'd12, 2'b10, "early_12");
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 40; i++) begin
      run_op($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    reset_n           = 1'b0;
    bus.start         = 1'b0;
    bus.data_operandA = '0;
    bus.ctrl_shamt    = '0;
    bus.ctrl_shiftop  = '0;
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_mid();
    test_early_done();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
